// File: rtl/floppy35_pkg.sv
// Shared floppy35 definitions: disk geometry and the SD responder state encoding.
package floppy35_pkg;

    localparam int BLOCK_BYTES        = 512;
    localparam int SECTORS_PER_TRACK  = 20;
    localparam int TRACKS_PER_SIDE    = 80;
    // Two sides of 80 tracks, 20 blocks per track.
    localparam int MAX_BLOCKS_DEFAULT = 2 * TRACKS_PER_SIDE * SECTORS_PER_TRACK;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_FETCH = 3'd1,
        RD_PUSH  = 3'd2,
        WR_ADDR  = 3'd3,
        WR_CAPT  = 3'd4,
        WR_STORE = 3'd5,
        DONE     = 3'd6
    } state_t;

endpackage

// File: rtl/floppy35_sd_responder.sv
// Block-level SD request responder: moves one 512-byte block between the
// track buffer and an external byte-wide backing store.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for sd_wr (preferred) or sd_rd
// RD_FETCH | fetch byte from backing store (or 0x00 when out of range)
// RD_PUSH  | one-cycle sd_buff_wr strobe of the fetched byte
// WR_ADDR  | present sd_buff_addr to the track buffer
// WR_CAPT  | capture sd_buff_din (valid one cycle after the address)
// WR_STORE | store captured byte (dropped when out of range)
// DONE     | sd_ack low for one cycle, marks completion
module floppy35_sd_responder
    import floppy35_pkg::*;
#(
    parameter int MAX_BLOCKS = MAX_BLOCKS_DEFAULT,
    parameter int MEM_AW     = 21
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       sd_lba,
    input  logic              sd_rd,
    input  logic              sd_wr,
    output logic              sd_ack,
    output logic [8:0]        sd_buff_addr,
    output logic [7:0]        sd_buff_dout,
    output logic              sd_buff_wr,
    input  logic [7:0]        sd_buff_din,
    input  logic [11:0]       img_blocks,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_din,
    input  logic [7:0]        mem_dout,
    input  logic              mem_ready,
    output logic              busy
);

    localparam logic [8:0] LAST_INDEX = 9'(BLOCK_BYTES - 1);

    state_t            state, state_next;
    logic [8:0]        index, index_next;
    logic [MEM_AW-10:0] lba_q, lba_next;
    logic              oor, oor_next;
    logic [7:0]        data_q, data_next;

    // State and datapath registers; reset aborts any transfer in progress.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            index  <= '0;
            lba_q  <= '0;
            oor    <= 1'b0;
            data_q <= '0;
        end else begin
            state  <= state_next;
            index  <= index_next;
            lba_q  <= lba_next;
            oor    <= oor_next;
            data_q <= data_next;
        end
    end

    // Next-state and strobe decode. The range check uses the full 32-bit lba
    // at acceptance; only the low bits are kept for addressing afterwards.
    always_comb begin
        state_next = state;
        index_next = index;
        lba_next   = lba_q;
        oor_next   = oor;
        data_next  = data_q;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        sd_buff_wr = 1'b0;
        case (state)
            IDLE: begin
                if (sd_wr || sd_rd) begin
                    lba_next   = sd_lba[MEM_AW-10:0];
                    oor_next   = (sd_lba >= {20'd0, img_blocks}) ||
                                 (sd_lba >= 32'(MAX_BLOCKS));
                    index_next = '0;
                    state_next = sd_wr ? WR_ADDR : RD_FETCH;
                end
            end
            RD_FETCH: begin
                if (oor) begin
                    data_next  = 8'h00;
                    state_next = RD_PUSH;
                end else begin
                    mem_rd = 1'b1;
                    if (mem_ready) begin
                        data_next  = mem_dout;
                        state_next = RD_PUSH;
                    end
                end
            end
            RD_PUSH: begin
                sd_buff_wr = 1'b1;
                if (index == LAST_INDEX) begin
                    state_next = DONE;
                end else begin
                    index_next = index + 9'd1;
                    state_next = RD_FETCH;
                end
            end
            WR_ADDR: state_next = WR_CAPT;
            WR_CAPT: begin
                data_next  = sd_buff_din;
                state_next = WR_STORE;
            end
            WR_STORE: begin
                mem_wr = !oor;
                if (oor || mem_ready) begin
                    if (index == LAST_INDEX) begin
                        state_next = DONE;
                    end else begin
                        index_next = index + 9'd1;
                        state_next = WR_ADDR;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign sd_ack       = (state != IDLE) && (state != DONE);
    assign busy         = (state != IDLE);
    assign sd_buff_addr = index;
    assign sd_buff_dout = data_q;
    assign mem_addr     = {lba_q, index};
    assign mem_din      = data_q;

endmodule

// File: tb/tb_floppy35_sd_responder.sv
// Scoreboard bench for floppy35_sd_responder: requests push expected strobes
// and memory transactions into queues; a monitor pops and compares them.
module tb_floppy35_sd_responder;
    import floppy35_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] sd_lba = '0;
    logic        sd_rd = 1'b0;
    logic        sd_wr = 1'b0;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din = '0;
    logic [11:0] img_blocks = '0;
    logic [20:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout = '0;
    logic        mem_ready = 1'b0;
    logic        busy;

    floppy35_sd_responder #(.MAX_BLOCKS(3200), .MEM_AW(21)) dut (
        .clk(clk), .reset_n(reset_n), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .img_blocks(img_blocks),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_ready(mem_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [8:0] addr; logic [7:0] data; } rd_exp_t;
    typedef struct { logic wr; logic [20:0] addr; logic [7:0] data; } mem_exp_t;

    rd_exp_t  rd_q[$];
    mem_exp_t mem_q[$];
    int checks = 0, errors = 0;
    int viol = 0, strobes_in_wr = 0, ack_falls = 0, total_strobes = 0;
    int mem_lat = 1, wait_cnt = 0;
    bit cur_wr = 1'b0;
    logic prev_ack = 1'b0;
    logic [8:0] prev_addr = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Backing store: byte n reads as n[7:0], ready after mem_lat cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_ready) begin
                mem_ready = 1'b0;
            end else if (mem_rd || mem_wr) begin
                wait_cnt++;
                if (wait_cnt >= mem_lat) begin
                    wait_cnt  = 0;
                    mem_ready = 1'b1;
                    mem_dout  = mem_addr[7:0];
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Track buffer: returns ~addr[7:0] one cycle after the address is shown.
    initial begin
        forever begin
            @(negedge clk);
            sd_buff_din = ~prev_addr[7:0];
            prev_addr   = sd_buff_addr;
        end
    end

    // Monitor: compares every strobe and memory handshake against the queues.
    initial begin
        rd_exp_t  e;
        mem_exp_t m;
        forever begin
            @(negedge clk);
            #1;
            if (sd_buff_wr) begin
                total_strobes++;
                if (cur_wr) strobes_in_wr++;
                if (rd_q.size() == 0) begin
                    check("rd_unexpected_strobe", {23'd0, sd_buff_addr}, 32'hFFFF_FFFF);
                end else begin
                    e = rd_q.pop_front();
                    check("rd_addr", {23'd0, sd_buff_addr}, {23'd0, e.addr});
                    check("rd_data", {24'd0, sd_buff_dout}, {24'd0, e.data});
                end
            end
            if (mem_rd && mem_wr) viol++;
            if ((mem_rd || mem_wr) && mem_q.size() == 0) begin
                viol++;
            end else if ((mem_rd || mem_wr) && mem_ready) begin
                m = mem_q.pop_front();
                check("mem_dir", {31'd0, mem_wr}, {31'd0, m.wr});
                check("mem_addr", {11'd0, mem_addr}, {11'd0, m.addr});
                if (m.wr) check("mem_din", {24'd0, mem_din}, {24'd0, m.data});
            end
            if (prev_ack && !sd_ack) ack_falls++;
            prev_ack = sd_ack;
        end
    end

    task automatic start_xfer(input bit wr, input bit both, input logic [31:0] lba,
                              input logic [11:0] blocks);
        bit oor;
        oor = (lba >= {20'd0, blocks}) || (lba >= 32'd3200);
        for (int i = 0; i < 512; i++) begin
            if (!wr) rd_q.push_back('{addr: i[8:0], data: (oor ? 8'h00 : i[7:0])});
            if (!oor) mem_q.push_back('{wr: wr, addr: 21'(lba * 512 + i),
                                        data: (wr ? ~i[7:0] : 8'h00)});
        end
        cur_wr     = wr;
        sd_lba     = lba;
        img_blocks = blocks;
        sd_wr      = wr;
        sd_rd      = !wr || both;
    endtask

    task automatic finish_xfer(input string name);
        int n;
        @(negedge clk); #2;
        check({name, "_ack_rise"}, {31'd0, sd_ack}, 32'd1);
        n = 0;
        while (!sd_ack && n < 10) begin @(negedge clk); #2; n++; end
        sd_rd = 1'b0;
        sd_wr = 1'b0;
        n = 0;
        while (sd_ack && n < 6000) begin @(negedge clk); #2; n++; end
        check({name, "_ack_fall_timeout"}, {31'd0, sd_ack}, 32'd0);
        check({name, "_done_busy"}, {31'd0, busy}, 32'd1);
        @(negedge clk); #2;
        check({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_idle_ack"}, {31'd0, sd_ack}, 32'd0);
        check({name, "_rd_left"}, rd_q.size(), 32'd0);
        check({name, "_mem_left"}, mem_q.size(), 32'd0);
        check({name, "_viol"}, viol, 32'd0);
        check({name, "_wr_strobes"}, strobes_in_wr, 32'd0);
        rd_q.delete();
        mem_q.delete();
        cur_wr = 1'b0;
    endtask

    initial begin
        int n, f0, s0;
        repeat (3) @(negedge clk);
        #2;
        check("rst_ack", {31'd0, sd_ack}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_buff_wr", {31'd0, sd_buff_wr}, 32'd0);
        check("rst_mem_addr", {11'd0, mem_addr}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk); #2;

        mem_lat = 1;
        start_xfer(1'b0, 1'b0, 32'd20, 12'd3200);
        finish_xfer("read20");

        mem_lat = 3;
        start_xfer(1'b1, 1'b0, 32'd3, 12'd3200);
        finish_xfer("write3");

        mem_lat = 1;
        start_xfer(1'b0, 1'b0, 32'd1600, 12'd1600);
        finish_xfer("oor_read");
        start_xfer(1'b1, 1'b0, 32'd1600, 12'd1600);
        finish_xfer("oor_write");
        start_xfer(1'b0, 1'b0, 32'd3200, 12'd4095);
        finish_xfer("oor_max");

        start_xfer(1'b1, 1'b1, 32'd5, 12'd3200);
        finish_xfer("both5");

        // Reset in the middle of a read, request held through reset.
        mem_lat = 2;
        start_xfer(1'b0, 1'b0, 32'd7, 12'd3200);
        n = 0;
        while (!(sd_buff_wr && sd_buff_addr == 9'd200) && n < 4000) begin
            @(negedge clk); #2; n++;
        end
        check("rst_mid_reach200", {23'd0, sd_buff_addr}, 32'd200);
        reset_n = 1'b0;
        rd_q.delete();
        mem_q.delete();
        @(negedge clk); #2;
        check("rst_mid_ack", {31'd0, sd_ack}, 32'd0);
        check("rst_mid_mem_rd", {31'd0, mem_rd}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_index", {23'd0, sd_buff_addr}, 32'd0);
        start_xfer(1'b0, 1'b0, 32'd7, 12'd3200);
        reset_n = 1'b1;
        finish_xfer("restart7");

        mem_lat = 1;
        f0 = ack_falls;
        s0 = total_strobes;
        for (int b = 0; b < 20; b++) begin
            start_xfer(1'b0, 1'b0, 32'(b), 12'd3200);
            finish_xfer("b2b");
        end
        check("b2b_ack_falls", ack_falls - f0, 32'd20);
        check("b2b_strobes", total_strobes - s0, 32'd10240);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
